// File: rtl/rr_arb_pkg.sv
// Shared types for the round-robin arbiter.
// Optional hold timeout is enabled with `RR_ARB_TIMEOUT_EN.
package rr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } rr_state_t;

    localparam int RR_NUM_REQ_DEFAULT = 16;

endpackage

// File: rtl/rr_arbiter_lsb_prio_enc.sv
// Lowest-set-bit priority encoder; idx is 0 when no bit is set.
module lsb_prio_enc #(
    parameter int W = 16
) (
    input  logic [W-1:0]         in,
    output logic [$clog2(W)-1:0] idx,
    output logic                 valid
);

    localparam int IW = $clog2(W);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (in[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and binary index.
// `RR_ARB_TIMEOUT_EN adds a MAX_HOLD-cycle preemption counter.
module rr_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NUM_REQ  = RR_NUM_REQ_DEFAULT,
    parameter int MAX_HOLD = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clk_en,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       grant_valid
);

    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || (NUM_REQ & (NUM_REQ - 1)) != 0) begin : g_bad_num_req
        $error("NUM_REQ must be a power of two >= 2");
    end
    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("MAX_HOLD must be >= 1");
    end

    rr_state_t          state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      idx_q, idx_d;

    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] masked;
    logic [IW-1:0]      masked_idx;
    logic               masked_valid;
    logic [IW-1:0]      req_idx;
    logic               req_valid;
    logic [IW-1:0]      winner;
    logic               expired;

    // Bits at or above ptr keep priority; wrap to the full set if empty.
    assign mask   = {NUM_REQ{1'b1}} << ptr_q;
    assign masked = req & mask;

    lsb_prio_enc #(.W(NUM_REQ)) u_enc_masked (
        .in    (masked),
        .idx   (masked_idx),
        .valid (masked_valid)
    );

    lsb_prio_enc #(.W(NUM_REQ)) u_enc_req (
        .in    (req),
        .idx   (req_idx),
        .valid (req_valid)
    );

    assign winner = masked_valid ? masked_idx : req_idx;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);

    logic [CW-1:0] hold_cnt_q, hold_cnt_d;

    // Counter holds cycles already spent; expire on the last allowed one.
    assign expired = (hold_cnt_q == CW'(MAX_HOLD - 1));

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            IDLE:    hold_cnt_d = '0;
            GRANT:   hold_cnt_d = hold_cnt_q + CW'(1);
            default: hold_cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
        end else if (clk_en) begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = GRANT;
                    grant_d = {{(NUM_REQ - 1){1'b0}}, 1'b1} << winner;
                    idx_d   = winner;
                    ptr_d   = winner + IW'(1);
                end
            end
            GRANT: begin
                if (!req[idx_q] || expired) begin
                    state_d = IDLE;
                    grant_d = '0;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            idx_q   <= '0;
        end else if (clk_en) begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = |grant_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: directed steps, then random traffic
// against a rotating-search reference model.
module tb_rr_arbiter;

    localparam int N  = 16;
    localparam int MH = 4;
    localparam int IW = $clog2(N);
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clk_en;
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_idx;
    logic          grant_valid;

    int checks = 0;
    int errors = 0;

    bit m_busy;
    int m_holder;
    int m_ptr;
    int m_held;

    always #5 clk = ~clk;

    rr_arbiter #(
        .NUM_REQ  (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clk_en      (clk_en),
        .req         (req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // First requester found walking upward from ptr, wrapping around.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy   = 1'b0;
        m_holder = 0;
        m_ptr    = 0;
        m_held   = 0;
    endtask

    task automatic model_step();
        int w;
        if (!clk_en) return;
        if (!m_busy) begin
            w = pick(req, m_ptr);
            if (w >= 0) begin
                m_busy   = 1'b1;
                m_holder = w;
                m_ptr    = (w + 1) % N;
                m_held   = 1;
            end
        end else if (!req[m_holder] || (TMO && m_held == MH)) begin
            m_busy = 1'b0;
        end else begin
            m_held++;
        end
    endtask

    task automatic check(input string tag);
        logic [N-1:0]  eg;
        logic [IW-1:0] ei;
        logic          ev;
        eg = m_busy ? (N'(1) << m_holder) : '0;
        ei = m_busy ? IW'(m_holder) : '0;
        ev = m_busy;
        checks++;
        assert (grant === eg) else begin
            errors++;
            $error("FAIL %s grant=%h expected %h", tag, grant, eg);
        end
        checks++;
        assert (grant_idx === ei) else begin
            errors++;
            $error("FAIL %s grant_idx=%0d expected %0d", tag, grant_idx, ei);
        end
        checks++;
        assert (grant_valid === ev) else begin
            errors++;
            $error("FAIL %s grant_valid=%b expected %b", tag, grant_valid, ev);
        end
    endtask

    task automatic expect_idx(input string tag, input int idx);
        checks++;
        assert (grant_valid === 1'b1 && grant_idx === IW'(idx)) else begin
            errors++;
            $error("FAIL %s valid=%b idx=%0d expected valid=1 idx=%0d",
                   tag, grant_valid, grant_idx, idx);
        end
    endtask

    task automatic expect_idle(input string tag);
        checks++;
        assert (grant_valid === 1'b0 && grant === '0) else begin
            errors++;
            $error("FAIL %s grant=%h expected 0", tag, grant);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check(tag);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("reset_async");
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        clk_en = 1'b1;
        req    = '0;
        model_reset();
        #2;
        check("reset");
        expect_idle("reset_idle");
        #6;
        rst_n = 1'b1;

        // Single requester
        req = 16'h0010;
        tick("single");
        expect_idx("single_idx", 4);
        tick("single_hold1");
        tick("single_hold2");
        expect_idx("single_held", 4);
        req = 16'h0000;
        tick("single_release");
        expect_idle("single_idle");

        // Rotation
        do_reset();
        req = 16'h0110;
        tick("rot_a");
        expect_idx("rot_first", 4);
        tick("rot_hold");
        req = 16'h0100;
        tick("rot_release4");
        expect_idle("rot_gap1");
        tick("rot_b");
        expect_idx("rot_second", 8);
        req = 16'h0010;
        tick("rot_release8");
        expect_idle("rot_gap2");
        tick("rot_c");
        expect_idx("rot_third", 4);

        // Wrap around 15 -> 0
        req = 16'h0000;
        tick("wrap_idle");
        req = 16'h8000;
        tick("wrap_g15");
        expect_idx("wrap_15", 15);
        req = 16'h0001;
        tick("wrap_rel15");
        req = 16'h8001;
        tick("wrap_g0");
        expect_idx("wrap_0", 0);
        req = 16'h8000;
        tick("wrap_rel0");
        expect_idle("wrap_gap");
        tick("wrap_g15b");
        expect_idx("wrap_15b", 15);

        // Async reset while granting
        req = 16'hFFFF;
        tick("rst_busy");
        do_reset();
        expect_idle("rst_drop");
        tick("rst_first");
        expect_idx("rst_first_idx", 0);

        // Clock enable freezes a pending release
        clk_en = 1'b0;
        req    = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            tick("clken_hold");
            expect_idx("clken_frozen", 0);
        end
        clk_en = 1'b1;
        tick("clken_release");
        expect_idle("clken_idle");
        tick("clken_next");
        expect_idx("clken_next_idx", 1);

        // Holder never releases
        do_reset();
        req = 16'h0110;
        for (int i = 0; i < 12; i++) tick("timeout");
        req = '0;
        tick("timeout_end");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end
            clk_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 2) == 0) begin
                req = N'($urandom);
            end else if ($urandom_range(0, 1) == 0) begin
                req = N'($urandom & $urandom & $urandom);
            end
            tick("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
